// File: rtl/suma_pipeline.sv
// suma_pipeline: multi-cycle N-bit adder/subtractor processing K bits per clock.
// Operands are accepted in IDLE, summed slice by slice in RUN with a carry register
// between slices, and presented with flags in DONE until the consumer takes them.
// Optional feature macro: SUMA_PIPELINE_FLAGS_EN enables the overflow, zero and
// negative flags; when undefined those ports are tied to 0.
module suma_pipeline #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] answer,
  output logic         carry_out,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  localparam int unsigned Slices = N / K;
  localparam int unsigned CntW   = (Slices > 1) ? $clog2(Slices) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;        // already inverted for subtract
  logic            carry_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    answer_q;
  logic            carry_out_q;

  logic [K:0]      slice_sum;
  logic [N-1:0]    answer_nxt;
  logic            last_slice;

`ifdef SUMA_PIPELINE_FLAGS_EN
  logic overflow_q;
  logic zero_q;
  logic negative_q;
`endif

  // Current slice sum and the answer as it will look once this slice is written.
  always_comb begin
    slice_sum  = {1'b0, a_q[int'(cnt_q) * K +: K]} + {1'b0, b_q[int'(cnt_q) * K +: K]}
               + {{K{1'b0}}, carry_q};
    answer_nxt = answer_q;
    answer_nxt[int'(cnt_q) * K +: K] = slice_sum[K-1:0];
    last_slice = (cnt_q == CntW'(Slices - 1));
  end

  // Control FSM and datapath registers; flags are captured on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      answer_q    <= '0;
      carry_out_q <= 1'b0;
`ifdef SUMA_PIPELINE_FLAGS_EN
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= input1;
            b_q      <= sub ? ~input2 : input2;
            carry_q  <= sub;
            cnt_q    <= '0;
            // Uncomputed slices must read 0 while running.
            answer_q <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          answer_q <= answer_nxt;
          carry_q  <= slice_sum[K];
          cnt_q    <= cnt_q + CntW'(1);
          if (last_slice) begin
            state_q     <= StDone;
            carry_out_q <= slice_sum[K];
`ifdef SUMA_PIPELINE_FLAGS_EN
            overflow_q  <= (a_q[N-1] == b_q[N-1]) && (answer_nxt[N-1] != a_q[N-1]);
            zero_q      <= (answer_nxt == '0);
            negative_q  <= answer_nxt[N-1];
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign answer    = answer_q;
  assign carry_out = carry_out_q;

`ifdef SUMA_PIPELINE_FLAGS_EN
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_suma_pipeline.sv
// Bench for suma_pipeline: three instances (K=4, K=1, K=8, N=8) share one input
// stream; each is checked cycle by cycle against an arithmetic reference model.
module tb_suma_pipeline;

  localparam int S [3] = '{2, 8, 1};  // slices per instance

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_ready;

  logic       in_ready  [3];
  logic       out_valid [3];
  logic [7:0] ans       [3];
  logic       co        [3];
  logic       ov        [3];
  logic       zr        [3];
  logic       ng        [3];

  int tests;
  int fails;

  suma_pipeline #(.N(8), .K(4)) u_dut_k4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .input1(a), .input2(b), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready),
    .answer(ans[0]), .carry_out(co[0]), .overflow(ov[0]), .zero(zr[0]), .negative(ng[0])
  );

  suma_pipeline #(.N(8), .K(1)) u_dut_k1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .input1(a), .input2(b), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready),
    .answer(ans[1]), .carry_out(co[1]), .overflow(ov[1]), .zero(zr[1]), .negative(ng[1])
  );

  suma_pipeline #(.N(8), .K(8)) u_dut_k8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .input1(a), .input2(b), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready),
    .answer(ans[2]), .carry_out(co[2]), .overflow(ov[2]), .zero(zr[2]), .negative(ng[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modulo-256 arithmetic, unsigned compare for borrow,
  // signed range check for overflow.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic s,
                       output logic [7:0] r, output logic c, output logic o);
    int sx, sy, sr, ur;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      ur = int'(x) + int'(y);
      sr = sx + sy;
      c  = (ur > 255);
    end else begin
      ur = int'(x) - int'(y) + 256;
      sr = sx - sy;
      c  = (x >= y);
    end
    r = ur[7:0];
    o = (sr > 127) || (sr < -128);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_inready_%0d", tag, d), in_ready[d], 1'b1);
      chk($sformatf("%s_outvalid_%0d", tag, d), out_valid[d], 1'b0);
      chk($sformatf("%s_answer_%0d", tag, d), ans[d], 8'h00);
      chk($sformatf("%s_carry_%0d", tag, d), co[d], 1'b0);
      chk($sformatf("%s_flags_%0d", tag, d), {ov[d], zr[d], ng[d]}, 3'b000);
    end
  endtask

  // Called #1 after the accept edge with out_ready high; walks nine cycles.
  task automatic check_run(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic s);
    logic [7:0] r;
    logic       c, o;
    logic [2:0] fl;
    int         bits;
    model(x, y, s, r, c, o);
`ifdef SUMA_PIPELINE_FLAGS_EN
    fl = {o, (r == 8'h00), r[7]};
`else
    fl = 3'b000;
`endif
    for (int cy = 1; cy <= 9; cy++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("%s_valid_k%0d_c%0d", tag, 8 / S[d], cy), out_valid[d], cy == S[d]);
        if (cy < S[d]) begin
          bits = cy * (8 / S[d]);
          chk($sformatf("%s_partial_k%0d_c%0d", tag, 8 / S[d], cy), ans[d],
              r & 8'((1 << bits) - 1));
          chk($sformatf("%s_busy_k%0d_c%0d", tag, 8 / S[d], cy), in_ready[d], 1'b0);
        end else if (cy == S[d]) begin
          chk($sformatf("%s_answer_k%0d", tag, 8 / S[d]), ans[d], r);
          chk($sformatf("%s_carry_k%0d", tag, 8 / S[d]), co[d], c);
          chk($sformatf("%s_flags_k%0d", tag, 8 / S[d]), {ov[d], zr[d], ng[d]}, fl);
          chk($sformatf("%s_busy_k%0d", tag, 8 / S[d]), in_ready[d], 1'b0);
        end else begin
          chk($sformatf("%s_ready_k%0d_c%0d", tag, 8 / S[d], cy), in_ready[d], 1'b1);
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("%s_pre_ready_%0d", tag, d), in_ready[d], 1'b1);
    a = x;
    b = y;
    sub = s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_run(tag, x, y, s);
  endtask

  initial begin
    logic [7:0] r1;
    logic       c1, o1;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("reset");

    // Directed cases.
    run_op("add_3c_15", 8'h3C, 8'h15, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1);
    run_op("sub_20_10", 8'h20, 8'h10, 1'b1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
    run_op("sub_00_00", 8'h00, 8'h00, 1'b1);

    // Randomized cases.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Backpressure: results held, new request ignored until handshake.
    @(negedge clk);
    a = 8'hA5;
    b = 8'h5B;
    sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model(8'hA5, 8'h5B, 1'b0, r1, c1, o1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    a = 8'h44;
    b = 8'h66;
    sub = 1'b1;
    in_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("bp_valid_%0d_h%0d", d, h), out_valid[d], 1'b1);
        chk($sformatf("bp_answer_%0d_h%0d", d, h), ans[d], r1);
        chk($sformatf("bp_carry_%0d_h%0d", d, h), co[d], c1);
`ifdef SUMA_PIPELINE_FLAGS_EN
        chk($sformatf("bp_flags_%0d_h%0d", d, h), {ov[d], zr[d], ng[d]},
            {o1, (r1 == 8'h00), r1[7]});
`endif
        chk($sformatf("bp_busy_%0d_h%0d", d, h), in_ready[d], 1'b0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("bp_release_ready_%0d", d), in_ready[d], 1'b1);
      chk($sformatf("bp_release_valid_%0d", d), out_valid[d], 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_run("bp_held_op", 8'h44, 8'h66, 1'b1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_k8_done", out_valid[2], 1'b1);
    chk("mid_k1_busy", in_ready[1], 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("post_rst");
    run_op("after_rst", 8'h12, 8'h34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
